prbs_gen: RTL and testbench

Parametrised Fibonacci LFSR pseudo-random word generator with run control and an AXI-stream-style output. It is the successor of the team's fixed 32-bit PRBS shifter. It adds configurable length and taps, multi-bit words per cycle, seed loading with zero-seed protection, and burst length with last-word marking. It feeds keystream/test-pattern consumers in the ChaCha20 datapath and, optionally, checks a returned pattern.

---
 rtl/prbs_gen.sv | 176 +++++++++++++++++
 tb/tb_prbs_gen.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_gen.sv
// Fibonacci LFSR word generator with run/stop control, bounded bursts and a valid/ready output.
// Define PRBS_CHECKER_EN to add a companion LFSR that counts mismatches on a returned pattern.
module prbs_gen #(
   parameter int          LFSR_LEN     = 32,
   parameter logic [63:0] TAP_MASK     = 64'h8020_0003,
   parameter int          OUT_W        = 32,
   parameter logic [63:0] SEED_DEFAULT = 64'h0000_ACE1
) (
   input  logic                i_aclk,
   input  logic                i_aresetn,
   input  logic                i_start,
   input  logic                i_stop,
   input  logic                i_seed_load,
   input  logic [LFSR_LEN-1:0] i_seed,
   input  logic [15:0]         i_len,
   output logic [OUT_W-1:0]    o_tdata,
   output logic                o_tvalid,
   input  logic                i_tready,
   output logic                o_tlast,
   output logic                o_busy,
`ifdef PRBS_CHECKER_EN
   input  logic                i_chk_valid,
   input  logic [OUT_W-1:0]    i_chk_data,
   output logic [15:0]         o_chk_err,
`endif
   output logic                o_done
);

   localparam logic [LFSR_LEN-1:0] L_TAPS = TAP_MASK[LFSR_LEN-1:0];
   localparam logic [LFSR_LEN-1:0] L_SEED = SEED_DEFAULT[LFSR_LEN-1:0];

   // OUT_W single-bit shifts chained in one cycle; the new bit enters at bit 0.
   function automatic logic [LFSR_LEN-1:0] adv(input logic [LFSR_LEN-1:0] s);
      logic [LFSR_LEN-1:0] v;
      logic                fb;
      v = s;
      for (int k = 0; k < OUT_W; k++) begin
         fb = ^(v & L_TAPS);
         v  = {v[LFSR_LEN-2:0], fb};
      end
      return v;
   endfunction

   typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

   state_t              r_fsm;
   state_t              w_fsm_nxt;
   logic [LFSR_LEN-1:0] r_lfsr;
   logic [LFSR_LEN-1:0] w_lfsr_nxt;
   logic [15:0]         r_rem;
   logic [15:0]         w_rem_nxt;
   logic                r_bounded;
   logic                w_bounded_nxt;
   logic                r_tlast;
   logic                w_tlast_nxt;
   logic                r_done;
   logic                w_done_nxt;
   logic                w_idle;
   logic                w_seed_take;
   logic [LFSR_LEN-1:0] w_seed_eff;
   logic [LFSR_LEN-1:0] w_adv_src;
   logic [LFSR_LEN-1:0] w_adv;

   assign w_idle      = (r_fsm == S_IDLE);
   assign w_seed_take = w_idle & i_seed_load;
   assign w_seed_eff  = (i_seed == '0) ? L_SEED : i_seed;
   // A seed arriving with start is advanced directly, so one adv() serves both paths.
   assign w_adv_src   = w_seed_take ? w_seed_eff : r_lfsr;
   assign w_adv       = adv(w_adv_src);

   // State register
   always_ff @(posedge i_aclk or negedge i_aresetn) begin
      if (!i_aresetn) r_fsm <= S_IDLE;
      else            r_fsm <= w_fsm_nxt;
   end

   // Next-state logic; stop outranks a simultaneous handshake.
   always_comb begin
      w_fsm_nxt = r_fsm;
      case (r_fsm)
         S_IDLE: if (i_start) w_fsm_nxt = S_RUN;
         S_RUN: begin
            if (i_stop)                   w_fsm_nxt = S_IDLE;
            else if (i_tready && r_tlast) w_fsm_nxt = S_IDLE;
         end
         default: w_fsm_nxt = S_IDLE;
      endcase
   end

   // Output/datapath next values, registered below.
   always_comb begin
      w_lfsr_nxt    = r_lfsr;
      w_rem_nxt     = r_rem;
      w_bounded_nxt = r_bounded;
      w_tlast_nxt   = r_tlast;
      w_done_nxt    = 1'b0;
      case (r_fsm)
         S_IDLE: begin
            if (i_start) begin
               w_lfsr_nxt    = w_adv;
               w_rem_nxt     = i_len;
               w_bounded_nxt = (i_len != 16'd0);
               w_tlast_nxt   = (i_len == 16'd1);
            end else if (i_seed_load) begin
               w_lfsr_nxt = w_seed_eff;
            end
         end
         S_RUN: begin
            if (i_stop) begin
               w_tlast_nxt = 1'b0;
            end else if (i_tready) begin
               if (r_tlast) begin
                  w_tlast_nxt = 1'b0;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_lfsr_nxt = w_adv;
                  if (r_bounded) begin
                     w_rem_nxt   = r_rem - 16'd1;
                     w_tlast_nxt = (r_rem == 16'd2);
                  end
               end
            end
         end
         default: w_done_nxt = 1'b0;
      endcase
   end

   always_ff @(posedge i_aclk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         r_lfsr    <= L_SEED;
         r_rem     <= 16'd0;
         r_bounded <= 1'b0;
         r_tlast   <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_lfsr    <= w_lfsr_nxt;
         r_rem     <= w_rem_nxt;
         r_bounded <= w_bounded_nxt;
         r_tlast   <= w_tlast_nxt;
         r_done    <= w_done_nxt;
      end
   end

   assign o_tdata  = r_lfsr[OUT_W-1:0];
   assign o_tvalid = (r_fsm == S_RUN);
   assign o_busy   = (r_fsm == S_RUN);
   assign o_tlast  = r_tlast;
   assign o_done   = r_done;

`ifdef PRBS_CHECKER_EN
   logic [LFSR_LEN-1:0] r_chk_lfsr;
   logic [15:0]         r_chk_err;
   logic [LFSR_LEN-1:0] w_chk_adv;
   logic                w_chk_miss;

   assign w_chk_adv  = adv(r_chk_lfsr);
   assign w_chk_miss = (i_chk_data != w_chk_adv[OUT_W-1:0]);

   // Reseeds together with the generator so a looped-back stream lines up word for word.
   always_ff @(posedge i_aclk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         r_chk_lfsr <= L_SEED;
         r_chk_err  <= 16'd0;
      end else if (w_seed_take) begin
         r_chk_lfsr <= w_seed_eff;
         r_chk_err  <= 16'd0;
      end else if (i_chk_valid) begin
         r_chk_lfsr <= w_chk_adv;
         if (w_chk_miss && (r_chk_err != 16'hFFFF)) r_chk_err <= r_chk_err + 16'd1;
      end
   end

   assign o_chk_err = r_chk_err;
`endif

endmodule

// File: tb/tb_prbs_gen.sv
// Directed bench for prbs_gen using a 4-bit LFSR (x^4+x^3+1 style taps 4'h9), word-wide and bit-wide.
// Checker scenarios are compiled in when PRBS_CHECKER_EN is defined.
module tb_prbs_gen;

   logic        clk;
   logic        aresetn;

   logic        start, stop, seed_load, tready;
   logic [3:0]  seed;
   logic [15:0] len;
   logic [3:0]  tdata;
   logic        tvalid, tlast, busy, done;

   logic        b_start, b_stop, b_seed_load, b_tready;
   logic [3:0]  b_seed;
   logic [15:0] b_len;
   logic [0:0]  b_tdata;
   logic        b_tvalid, b_tlast, b_busy, b_done;

`ifdef PRBS_CHECKER_EN
   logic        chk_valid;
   logic [3:0]  chk_data;
   logic [15:0] chk_err;
   logic        b_chk_valid;
   logic [0:0]  b_chk_data;
   logic [15:0] b_chk_err;
`endif

   int n_vec;
   int n_err;

   prbs_gen #(.LFSR_LEN(4), .TAP_MASK(64'h9), .OUT_W(4), .SEED_DEFAULT(64'h1)) u_dut (
      .i_aclk(clk), .i_aresetn(aresetn), .i_start(start), .i_stop(stop),
      .i_seed_load(seed_load), .i_seed(seed), .i_len(len),
      .o_tdata(tdata), .o_tvalid(tvalid), .i_tready(tready), .o_tlast(tlast),
      .o_busy(busy),
`ifdef PRBS_CHECKER_EN
      .i_chk_valid(chk_valid), .i_chk_data(chk_data), .o_chk_err(chk_err),
`endif
      .o_done(done)
   );

   prbs_gen #(.LFSR_LEN(4), .TAP_MASK(64'h9), .OUT_W(1), .SEED_DEFAULT(64'h1)) u_dut_bit (
      .i_aclk(clk), .i_aresetn(aresetn), .i_start(b_start), .i_stop(b_stop),
      .i_seed_load(b_seed_load), .i_seed(b_seed), .i_len(b_len),
      .o_tdata(b_tdata), .o_tvalid(b_tvalid), .i_tready(b_tready), .o_tlast(b_tlast),
      .o_busy(b_busy),
`ifdef PRBS_CHECKER_EN
      .i_chk_valid(b_chk_valid), .i_chk_data(b_chk_data), .o_chk_err(b_chk_err),
`endif
      .o_done(b_done)
   );

   // Clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1);
   end

   // Driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic do_load, input logic [3:0] s, input logic [15:0] l);
      seed_load = do_load;
      seed      = s;
      len       = l;
      start     = 1'b1;
      step();
      start     = 1'b0;
      seed_load = 1'b0;
   endtask

   task automatic test_reset();
      aresetn = 1'b1;
      #2 aresetn = 1'b0;
      step();
      step();
      n_vec++;
      if (tdata !== 4'h1 || tvalid !== 1'b0 || tlast !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         n_err++;
         $display("FAIL reset: tdata=%h tvalid=%b tlast=%b busy=%b done=%b, want 1 0 0 0 0",
                  tdata, tvalid, tlast, busy, done);
      end
      n_vec++;
      if (b_tdata !== 1'b1 || b_tvalid !== 1'b0 || b_busy !== 1'b0) begin
         n_err++;
         $display("FAIL reset_bit: tdata=%b tvalid=%b busy=%b, want 1 0 0", b_tdata, b_tvalid, b_busy);
      end
      aresetn = 1'b1;
      step();
   endtask

   task automatic test_bounded();
      logic [3:0] exp_w [4] = '{4'hE, 4'hB, 4'h2, 4'h3};
      tready = 1'b1;
      launch(1'b1, 4'h1, 16'd4);
      for (int i = 0; i < 4; i++) begin
         n_vec++;
         if (tvalid !== 1'b1 || tdata !== exp_w[i] || tlast !== (i == 3) || done !== 1'b0) begin
            n_err++;
            $display("FAIL bounded_w%0d: tdata=%h tvalid=%b tlast=%b done=%b, want %h 1 %b 0",
                     i, tdata, tvalid, tlast, done, exp_w[i], (i == 3));
         end
         step();
      end
      n_vec++;
      if (done !== 1'b1 || busy !== 1'b0 || tvalid !== 1'b0) begin
         n_err++;
         $display("FAIL bounded_done: done=%b busy=%b tvalid=%b, want 1 0 0", done, busy, tvalid);
      end
      step();
      n_vec++;
      if (done !== 1'b0) begin
         n_err++;
         $display("FAIL done_pulse: done=%b, want 0", done);
      end
   endtask

   task automatic test_zero_seed();
      logic [3:0] exp_w [2] = '{4'hE, 4'hB};
      launch(1'b1, 4'h0, 16'd2);
      for (int i = 0; i < 2; i++) begin
         n_vec++;
         if (tvalid !== 1'b1 || tdata !== exp_w[i] || tlast !== (i == 1)) begin
            n_err++;
            $display("FAIL zero_seed_w%0d: tdata=%h tvalid=%b tlast=%b, want %h 1 %b",
                     i, tdata, tvalid, tlast, exp_w[i], (i == 1));
         end
         step();
      end
      n_vec++;
      if (done !== 1'b1) begin
         n_err++;
         $display("FAIL zero_seed_done: done=%b, want 1", done);
      end
      step();
   endtask

   task automatic test_stall();
      launch(1'b1, 4'h1, 16'd4);
      step();
      tready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         n_vec++;
         if (tdata !== 4'hB || tvalid !== 1'b1 || tlast !== 1'b0) begin
            n_err++;
            $display("FAIL stall_c%0d: tdata=%h tvalid=%b tlast=%b, want B 1 0", i, tdata, tvalid, tlast);
         end
      end
      tready = 1'b1;
      step();
      n_vec++;
      if (tdata !== 4'h2 || tvalid !== 1'b1) begin
         n_err++;
         $display("FAIL stall_resume: tdata=%h tvalid=%b, want 2 1", tdata, tvalid);
      end
      step();
      n_vec++;
      if (tdata !== 4'h3 || tlast !== 1'b1) begin
         n_err++;
         $display("FAIL stall_last: tdata=%h tlast=%b, want 3 1", tdata, tlast);
      end
      step();
      step();
   endtask

   task automatic test_stop();
      logic [3:0] exp_w [4] = '{4'h2, 4'h3, 4'hD, 4'h6};
      launch(1'b1, 4'h1, 16'd4);
      step();
      stop = 1'b1;
      step();
      stop = 1'b0;
      n_vec++;
      if (tvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         n_err++;
         $display("FAIL stop: tvalid=%b busy=%b done=%b, want 0 0 0", tvalid, busy, done);
      end
      step();
      n_vec++;
      if (done !== 1'b0 || tdata !== 4'hB) begin
         n_err++;
         $display("FAIL stop_hold: done=%b tdata=%h, want 0 B", done, tdata);
      end
      stop = 1'b1;
      step();
      stop = 1'b0;
      n_vec++;
      if (busy !== 1'b0 || tdata !== 4'hB) begin
         n_err++;
         $display("FAIL stop_idle: busy=%b tdata=%h, want 0 B", busy, tdata);
      end
      launch(1'b0, 4'h0, 16'd4);
      for (int i = 0; i < 4; i++) begin
         n_vec++;
         if (tvalid !== 1'b1 || tdata !== exp_w[i] || tlast !== (i == 3)) begin
            n_err++;
            $display("FAIL continue_w%0d: tdata=%h tvalid=%b tlast=%b, want %h 1 %b",
                     i, tdata, tvalid, tlast, exp_w[i], (i == 3));
         end
         if (i == 1) begin
            start     = 1'b1;
            seed_load = 1'b1;
            seed      = 4'h5;
            len       = 16'd9;
         end
         step();
         start     = 1'b0;
         seed_load = 1'b0;
      end
      n_vec++;
      if (done !== 1'b1) begin
         n_err++;
         $display("FAIL continue_done: done=%b, want 1", done);
      end
   endtask

   task automatic test_back_to_back();
      launch(1'b0, 4'h0, 16'd1);
      n_vec++;
      if (tvalid !== 1'b1 || tdata !== 4'h4 || tlast !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_len1: tdata=%h tvalid=%b tlast=%b, want 4 1 1", tdata, tvalid, tlast);
      end
      step();
      n_vec++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_done: done=%b busy=%b, want 1 0", done, busy);
      end
      step();
   endtask

   task automatic test_unbounded();
      logic [15:0] exp_bits = 16'b1100_0100_1101_0111;
      b_tready    = 1'b1;
      b_seed_load = 1'b1;
      b_seed      = 4'h1;
      b_len       = 16'd0;
      b_start     = 1'b1;
      step();
      b_start     = 1'b0;
      b_seed_load = 1'b0;
      for (int i = 0; i < 16; i++) begin
         n_vec++;
         if (b_tvalid !== 1'b1 || b_tdata[0] !== exp_bits[i] || b_tlast !== 1'b0) begin
            n_err++;
            $display("FAIL unbounded_b%0d: bit=%b tvalid=%b tlast=%b, want %b 1 0",
                     i, b_tdata, b_tvalid, b_tlast, exp_bits[i]);
         end
         step();
      end
      b_stop = 1'b1;
      step();
      b_stop = 1'b0;
      n_vec++;
      if (b_tvalid !== 1'b0 || b_done !== 1'b0) begin
         n_err++;
         $display("FAIL unbounded_stop: tvalid=%b done=%b, want 0 0", b_tvalid, b_done);
      end
   endtask

   task automatic test_reset_mid_run();
      launch(1'b1, 4'h1, 16'd0);
      step();
      step();
      #1 aresetn = 1'b0;
      #1;
      n_vec++;
      if (tdata !== 4'h1 || tvalid !== 1'b0 || busy !== 1'b0 || tlast !== 1'b0 || done !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mid_run: tdata=%h tvalid=%b busy=%b tlast=%b done=%b, want 1 0 0 0 0",
                  tdata, tvalid, busy, tlast, done);
      end
      #1 aresetn = 1'b1;
      step();
      launch(1'b0, 4'h0, 16'd1);
      n_vec++;
      if (tdata !== 4'hE || tlast !== 1'b1) begin
         n_err++;
         $display("FAIL after_reset: tdata=%h tlast=%b, want E 1", tdata, tlast);
      end
      step();
      step();
   endtask

`ifdef PRBS_CHECKER_EN
   task automatic chk_run(input logic [5:0] flip_sel);
      launch(1'b1, 4'h1, 16'd6);
      for (int i = 0; i < 6; i++) begin
         chk_valid = tvalid & tready;
         chk_data  = tdata ^ {3'b000, flip_sel[i]};
         step();
      end
      chk_valid = 1'b0;
      chk_data  = 4'h0;
   endtask

   task automatic test_checker();
      chk_run(6'b000000);
      n_vec++;
      if (chk_err !== 16'd0) begin
         n_err++;
         $display("FAIL chk_clean: err=%0d, want 0", chk_err);
      end
      step();
      chk_run(6'b010110);
      n_vec++;
      if (chk_err !== 16'd3) begin
         n_err++;
         $display("FAIL chk_flip3: err=%0d, want 3", chk_err);
      end
      step();
      seed_load = 1'b1;
      seed      = 4'h1;
      step();
      seed_load = 1'b0;
      n_vec++;
      if (chk_err !== 16'd0) begin
         n_err++;
         $display("FAIL chk_clear: err=%0d, want 0", chk_err);
      end
   endtask
`endif

   initial begin
      n_vec       = 0;
      n_err       = 0;
      aresetn     = 1'b1;
      start       = 1'b0;
      stop        = 1'b0;
      seed_load   = 1'b0;
      seed        = 4'h0;
      len         = 16'd0;
      tready      = 1'b1;
      b_start     = 1'b0;
      b_stop      = 1'b0;
      b_seed_load = 1'b0;
      b_seed      = 4'h0;
      b_len       = 16'd0;
      b_tready    = 1'b1;
`ifdef PRBS_CHECKER_EN
      chk_valid   = 1'b0;
      chk_data    = 4'h0;
      b_chk_valid = 1'b0;
      b_chk_data  = 1'b0;
`endif
      test_reset();
      test_bounded();
      test_zero_seed();
      test_stall();
      test_stop();
      test_back_to_back();
      test_unbounded();
      test_reset_mid_run();
`ifdef PRBS_CHECKER_EN
      test_checker();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
